scoreboard_hazard_unit: RTL and testbench
=========================================

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 The block SHALL expose parameters, one per line:
- REG_ADDR_W, default 5, register index width; register file holds 2**REG_ADDR_W entries.
- LAT_W, default 3, width of the per-register countdown and of id_lat.
REQ-002 The block SHALL have ports, one per line:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_rs1, id_rs2  input  REG_ADDR_W  source register indices.
- id_use_rs1, id_use_rs2  input  1  the matching source is actually read.
- id_rd  input  REG_ADDR_W  destination register index.
- id_reg_wr  input  1  the ID instruction writes id_rd.
- id_lat  input  LAT_W  cycles after issue before the result can be forwarded (0 = forwardable immediately, e.g. ALU op).
- id_flush  input  1  kill the ID instruction this cycle (branch redirect).
- stall  output  1  freeze IF and ID.
- flush_id_ex  output  1  insert a bubble into ID/EX.
- busy_vec  output  2**REG_ADDR_W  bit i set when the countdown for register i is nonzero.
- stall_cycles  output  32  performance counter (see Configuration).

Function
REQ-003 The block SHALL keep one LAT_W-bit countdown cnt[i] per register; register 0 SHALL always read 0.
REQ-004 The raw hazard for source s SHALL be id_use_s && id_rs_s!=0 && cnt[id_rs_s]!=0.
REQ-005 The WAW hazard SHALL be id_reg_wr && id_rd!=0 && cnt[id_rd] > id_lat.
REQ-006 stall SHALL be combinational: id_valid && !id_flush && (raw_rs1 || raw_rs2 || waw).
REQ-007 flush_id_ex SHALL equal stall || id_flush.
REQ-008 An issue SHALL occur when id_valid && !stall && !id_flush.
REQ-009 On an issue with id_reg_wr && id_rd!=0 && id_lat!=0, cnt[id_rd] SHALL load id_lat at the next edge.
REQ-010 Every other nonzero cnt[i] SHALL decrement by 1 per cycle and saturate at 0.
REQ-011 When an issue and a decrement target the same register in the same cycle, the load SHALL win; the loaded value is not decremented that cycle.
REQ-012 The resulting stall length SHALL be exactly id_lat cycles for a back-to-back dependent consumer; id_lat=1 gives the classic single-cycle load-use bubble.
REQ-013 A killed (id_flush) or stalled instruction SHALL NOT modify any countdown.
REQ-014 busy_vec SHALL be a registered image of the countdowns, with bit i = (cnt[i]!=0).

Reset
REQ-015 While rst_n=0, all cnt[i], busy_vec and stall_cycles SHALL be 0, asynchronously.
REQ-016 While in reset, stall SHALL be 0 and flush_id_ex SHALL equal id_flush.
REQ-017 Reset asserted mid-countdown SHALL discard all pending hazards; the first post-reset consumer SHALL issue without stalling.

Configuration
REQ-018 With macro HAZARD_PERF_CNT_EN defined, stall_cycles SHALL increment by 1 on every cycle with stall=1 and saturate at 32'hFFFF_FFFF.
REQ-019 Without HAZARD_PERF_CNT_EN, stall_cycles SHALL be tied to 0 and no counter flops SHALL be synthesised.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load-use: issue rd=5 with id_lat=1, then a consumer with rs1=5 -> stall=1 for 1 cycle, then issue.
- Long latency: issue rd=7 with id_lat=4, then a consumer with rs2=7 -> stall=1 for exactly 4 cycles; busy_vec[7] clears after 4 cycles.
- x0 and unused sources: producer rd=0 with id_lat=3, or consumer with id_use_rs1=0 on a busy reg -> stall=0 and busy_vec unchanged.
- WAW: cnt[9]=3 and a new writer rd=9 with id_lat=1 -> stall until cnt[9]<=1; then cnt[9] reloads to 1.
- Flush and reset: a consumer stalled on a busy reg receives id_flush=1 -> stall=0, flush_id_ex=1, no countdown change; rst_n pulsed low with cnt[3]=2 -> busy_vec=0 and the next consumer of reg 3 issues.
- Perf counter (HAZARD_PERF_CNT_EN): the id_lat=4 scenario above -> stall_cycles=4; without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_unit
//   Per-register latency scoreboard for an in-order pipeline. Each architectural
//   register has a small countdown that is loaded when a producer issues and
//   ticks down once per cycle. The instruction in ID is held while any source
//   it reads is still counting, or while an older, longer-latency write to the
//   same destination would complete after it (WAW).
//
// Parameters
//   REG_ADDR_W  register index width (2**REG_ADDR_W registers)
//   LAT_W       countdown / id_lat width
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   id_valid                 ID holds a valid instruction
//   id_rs1/id_rs2            source indices, qualified by id_use_rs1/id_use_rs2
//   id_rd, id_reg_wr         destination index and its write enable
//   id_lat                   cycles until the result is forwardable (0 = now)
//   id_flush                 kill the ID instruction this cycle
//   stall                    freeze IF and ID (combinational)
//   flush_id_ex              bubble into ID/EX (stall or kill)
//   busy_vec                 registered image of (cnt[i] != 0)
//   stall_cycles             stalled-cycle performance counter
//
// Configuration
//   HAZARD_PERF_CNT_EN       when defined, stall_cycles counts stalled cycles
//                            (saturating); otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module scoreboard_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LAT_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [REG_ADDR_W-1:0]      id_rs1,
  input  logic [REG_ADDR_W-1:0]      id_rs2,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic [REG_ADDR_W-1:0]      id_rd,
  input  logic                       id_reg_wr,
  input  logic [LAT_W-1:0]           id_lat,
  input  logic                       id_flush,
  output logic                       stall,
  output logic                       flush_id_ex,
  output logic [(2**REG_ADDR_W)-1:0] busy_vec,
  output logic [31:0]                stall_cycles
);

  localparam int unsigned NREG = 2 ** REG_ADDR_W;

  logic [LAT_W-1:0] r_cnt     [NREG];
  logic [LAT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  r_busy;

  logic w_raw_rs1;
  logic w_raw_rs2;
  logic w_waw;
  logic w_stall;
  logic w_issue;
  logic w_load;

  // Hazard detection. Countdowns are cleared asynchronously in reset, so the
  // explicit rst_n term only guards against glitches while reset is applied.
  always_comb begin
    w_raw_rs1 = id_use_rs1 && (id_rs1 != '0) && (r_cnt[id_rs1] != '0);
    w_raw_rs2 = id_use_rs2 && (id_rs2 != '0) && (r_cnt[id_rs2] != '0);
    w_waw     = id_reg_wr  && (id_rd  != '0) && (r_cnt[id_rd] > id_lat);
    w_stall   = rst_n && id_valid && !id_flush && (w_raw_rs1 || w_raw_rs2 || w_waw);
    w_issue   = id_valid && !w_stall && !id_flush;
    w_load    = w_issue && id_reg_wr && (id_rd != '0) && (id_lat != '0);
  end

  // Next countdown values: a load on issue overrides the decrement of the
  // same register; register 0 never holds a pending write.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = '0;
      if (i != 0) begin
        if (w_load && (id_rd == REG_ADDR_W'(i))) begin
          w_cnt_nxt[i] = id_lat;
        end else if (r_cnt[i] != '0) begin
          w_cnt_nxt[i] = r_cnt[i] - LAT_W'(1);
        end
      end
    end
  end

  // busy_vec is registered from the next-state values so it always matches
  // the countdowns it mirrors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_busy[i] <= (w_cnt_nxt[i] != '0);
      end
    end
  end

  assign stall       = w_stall;
  assign flush_id_ex = w_stall || id_flush;
  assign busy_vec    = r_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_hazard_unit
//   Directed bench for scoreboard_hazard_unit: reset behaviour, load-use,
//   long latency, x0/unused sources, WAW, flush, mid-countdown reset,
//   back-to-back producers and the optional stall counter.
// -----------------------------------------------------------------------------
module tb_scoreboard_hazard_unit;

  localparam int unsigned RW = 5;
  localparam int unsigned LW = 3;
  localparam int unsigned NR = 2 ** RW;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] id_rd;
  logic          id_reg_wr;
  logic [LW-1:0] id_lat;
  logic          id_flush;
  logic          stall;
  logic          flush_id_ex;
  logic [NR-1:0] busy_vec;
  logic [31:0]   stall_cycles;

  int vecs;
  int errs;

  scoreboard_hazard_unit #(
    .REG_ADDR_W(RW),
    .LAT_W     (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_wr   (id_reg_wr),
    .id_lat      (id_lat),
    .id_flush    (id_flush),
    .stall       (stall),
    .flush_id_ex (flush_id_ex),
    .busy_vec    (busy_vec),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 1 more later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid   = 1'b0;
    id_rs1     = '0;
    id_rs2     = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_rd      = '0;
    id_reg_wr  = 1'b0;
    id_lat     = '0;
    id_flush   = 1'b0;
  endtask

  task automatic instr(input logic [RW-1:0] rs1, input logic u1,
                       input logic [RW-1:0] rs2, input logic u2,
                       input logic [RW-1:0] rd,  input logic wr,
                       input logic [LW-1:0] lat);
    id_valid   = 1'b1;
    id_rs1     = rs1;
    id_use_rs1 = u1;
    id_rs2     = rs2;
    id_use_rs2 = u2;
    id_rd      = rd;
    id_reg_wr  = wr;
    id_lat     = lat;
    id_flush   = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 3'd2);
    id_flush = 1'b1;
    #2;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b exp=0", stall); end
    vecs++; if (flush_id_ex !== 1'b1) begin errs++; $display("FAIL reset_flush_id_ex got=%b exp=1", flush_id_ex); end
    vecs++; if (busy_vec !== '0) begin errs++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    vecs++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    id_flush = 1'b0;
    #1;
    vecs++; if (flush_id_ex !== 1'b0) begin errs++; $display("FAIL reset_flush_follow got=%b exp=0", flush_id_ex); end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    int n;
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1);
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_producer_stall got=%b exp=0", stall); end
    tick();
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 3'd0);
    #1;
    vecs++; if (busy_vec !== 32'h0000_0020) begin errs++; $display("FAIL lu_busy got=%h exp=00000020", busy_vec); end
    vecs++; if (flush_id_ex !== 1'b1) begin errs++; $display("FAIL lu_flush_id_ex got=%b exp=1", flush_id_ex); end
    n = 0;
    while (stall === 1'b1 && n < 20) begin tick(); n++; end
    vecs++; if (n != 1) begin errs++; $display("FAIL lu_stall_len got=%0d exp=1", n); end
    vecs++; if (busy_vec !== '0) begin errs++; $display("FAIL lu_busy_clear got=%h exp=0", busy_vec); end
    drain();
  endtask

  task automatic test_long_latency();
    int n;
    logic [31:0] sc0;
    sc0 = stall_cycles;
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd4);
    tick();
    instr(5'd1, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 3'd0);
    #1;
    vecs++; if (busy_vec !== 32'h0000_0080) begin errs++; $display("FAIL ll_busy got=%h exp=00000080", busy_vec); end
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      vecs++; if (busy_vec[7] !== 1'b1) begin errs++; $display("FAIL ll_busy_hold cyc=%0d got=%b exp=1", n, busy_vec[7]); end
      tick(); n++;
    end
    vecs++; if (n != 4) begin errs++; $display("FAIL ll_stall_len got=%0d exp=4", n); end
    vecs++; if (busy_vec[7] !== 1'b0) begin errs++; $display("FAIL ll_busy_clear got=%b exp=0", busy_vec[7]); end
    vecs++;
    if (stall_cycles !== (PERF ? sc0 + 32'd4 : 32'd0)) begin
      errs++; $display("FAIL ll_stall_cycles got=%0d exp=%0d", stall_cycles, PERF ? sc0 + 32'd4 : 32'd0);
    end
    drain();
  endtask

  task automatic test_x0_unused();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd3);
    tick();
    instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 3'd0);
    #1;
    vecs++; if (busy_vec !== '0) begin errs++; $display("FAIL x0_busy got=%h exp=0", busy_vec); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL x0_stall got=%b exp=0", stall); end
    tick();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd3);
    tick();
    instr(5'd6, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 3'd0);
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL unused_stall got=%b exp=0", stall); end
    tick();
    vecs++; if (busy_vec !== 32'h0000_0040) begin errs++; $display("FAIL unused_busy got=%h exp=00000040", busy_vec); end
    drain();
  endtask

  task automatic test_waw();
    int n;
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd3);
    tick();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 20) begin tick(); n++; end
    vecs++; if (n != 2) begin errs++; $display("FAIL waw_stall_len got=%0d exp=2", n); end
    tick();
    idle();
    #1;
    vecs++; if (busy_vec !== 32'h0000_0200) begin errs++; $display("FAIL waw_reload got=%h exp=00000200", busy_vec); end
    tick();
    vecs++; if (busy_vec !== '0) begin errs++; $display("FAIL waw_expire got=%h exp=0", busy_vec); end
    drain();
  endtask

  task automatic test_flush();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 3'd3);
    tick();
    instr(5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 3'd2);
    #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL fl_pre_stall got=%b exp=1", stall); end
    id_flush = 1'b1;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL fl_stall got=%b exp=0", stall); end
    vecs++; if (flush_id_ex !== 1'b1) begin errs++; $display("FAIL fl_flush_id_ex got=%b exp=1", flush_id_ex); end
    tick();
    vecs++; if (busy_vec !== 32'h0000_1000) begin errs++; $display("FAIL fl_busy got=%h exp=00001000", busy_vec); end
    drain();
  endtask

  task automatic test_reset_mid();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd3);
    tick();
    idle();
    tick();
    vecs++; if (busy_vec !== 32'h0000_0008) begin errs++; $display("FAIL rm_pre_busy got=%h exp=00000008", busy_vec); end
    rst_n = 1'b0;
    #1;
    vecs++; if (busy_vec !== '0) begin errs++; $display("FAIL rm_busy got=%h exp=0", busy_vec); end
    vecs++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL rm_stall_cycles got=%0d exp=0", stall_cycles); end
    #2;
    rst_n = 1'b1;
    instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rm_consumer_stall got=%b exp=0", stall); end
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 3'd2);
    tick();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd1);
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b_second_stall got=%b exp=0", stall); end
    tick();
    instr(5'd4, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 3'd0);
    #1;
    vecs++; if (busy_vec !== 32'h0000_0014) begin errs++; $display("FAIL b2b_busy got=%h exp=00000014", busy_vec); end
    n = 0;
    while (stall === 1'b1 && n < 20) begin tick(); n++; end
    vecs++; if (n != 1) begin errs++; $display("FAIL b2b_stall_len got=%0d exp=1", n); end
    drain();
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_long_latency();
    test_x0_unused();
    test_waw();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
